// File: rtl/cordic_twiddle_rotator_if.sv
// Request/response bundle for the CORDIC twiddle rotator.
// The master issues a code and sample; the slave returns the rotated sample and error flag.
interface cordic_twiddle_rotator_if #(
    parameter int N_ITER = 11,
    parameter int IN_W   = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2*N_ITER+1:0]      in_code;
    logic signed [IN_W-1:0]   in_re;
    logic signed [IN_W-1:0]   in_im;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [IN_W+1:0]   out_re;
    logic signed [IN_W+1:0]   out_im;
    logic                     code_err;

    modport master (
        output in_valid, in_code, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, code_err
    );

    modport slave (
        input  in_valid, in_code, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, code_err
    );
endinterface

// File: rtl/cordic_twiddle_rotator.sv
// Iterative CORDIC rotator driven by a precomputed direction code (quadrant + N_ITER micro-rotations).
// Latency 11 cycles accept-to-valid; one sample in flight, in_ready low until the result is taken.
module cordic_twiddle_rotator #(
    parameter int N_ITER = 11,
    parameter int IN_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    cordic_twiddle_rotator_if.slave bus
);
    localparam int W   = IN_W + 2;
    localparam int ITW = $clog2(N_ITER + 1);
    localparam logic [ITW-1:0] LAST_ITER = ITW'(N_ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_ROT, S_DONE} state_t;

    state_t                 r_state;
    logic [ITW-1:0]         r_iter;
    logic signed [W-1:0]    r_x;
    logic signed [W-1:0]    r_y;
    logic [2*N_ITER-1:0]    r_dirs;
    logic                   r_out_valid;
    logic                   r_code_err;

    logic signed [W-1:0]    w_re_ext;
    logic signed [W-1:0]    w_im_ext;
    logic signed [W-1:0]    w_x0;
    logic signed [W-1:0]    w_y0;
    logic signed [W-1:0]    w_x_sh;
    logic signed [W-1:0]    w_y_sh;
    logic [1:0]             w_fld;

    assign w_re_ext = {{2{bus.in_re[IN_W-1]}}, bus.in_re};
    assign w_im_ext = {{2{bus.in_im[IN_W-1]}}, bus.in_im};
    assign w_x_sh   = r_x >>> r_iter;
    assign w_y_sh   = r_y >>> r_iter;
    // Direction fields are consumed LSB-first as the code shifts down each iteration.
    assign w_fld    = r_dirs[1:0];

    always_comb begin
        w_x0 = w_re_ext;
        w_y0 = w_im_ext;
        case (bus.in_code[1:0])
            2'b01: begin w_x0 = -w_im_ext; w_y0 =  w_re_ext; end
            2'b10: begin w_x0 = -w_re_ext; w_y0 = -w_im_ext; end
            2'b11: begin w_x0 =  w_im_ext; w_y0 = -w_re_ext; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_iter      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_dirs      <= '0;
            r_out_valid <= 1'b0;
            r_code_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_x     <= w_x0;
                        r_y     <= w_y0;
                        r_dirs  <= bus.in_code[2*N_ITER+1:2];
                        r_iter  <= '0;
                        r_state <= S_ROT;
                    end
                end
                S_ROT: begin
                    case (w_fld)
                        2'b01: begin r_x <= r_x - w_y_sh; r_y <= r_y + w_x_sh; end
                        2'b10: begin r_x <= r_x + w_y_sh; r_y <= r_y - w_x_sh; end
                        2'b11: r_code_err <= 1'b1;
                        default: ;
                    endcase
                    r_dirs <= r_dirs >> 2;
                    r_iter <= r_iter + ITW'(1);
                    if (r_iter == LAST_ITER) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.out_re    = r_out_valid ? r_x : '0;
    assign bus.out_im    = r_out_valid ? r_y : '0;
    assign bus.code_err  = r_code_err;
endmodule

// File: tb/tb_cordic_twiddle_rotator.sv
// Scoreboarded bench: stimulus pushes model results, a negedge monitor pops on each transfer.
module tb_cordic_twiddle_rotator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_twiddle_rotator_if #(.N_ITER(11), .IN_W(16)) bus ();
    cordic_twiddle_rotator #(.N_ITER(11), .IN_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int  re;
        int  im;
        real ang;
        bit  chk_ang;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic rdy_main = 1'b1;
    logic rand_rdy = 1'b0;
    logic rnd_bit  = 1'b1;

    assign bus.out_ready = rand_rdy ? rnd_bit : rdy_main;

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Reference: quadrant rotation then signed micro-rotations with floor shifts on plain ints.
    function automatic void model(input logic [23:0] code, input int re, input int im,
                                  output int ox, output int oy, output real ang);
        int  x, y, t;
        real p;
        logic [1:0] f;
        case (code[1:0])
            2'd0: begin x = re;  y = im;  end
            2'd1: begin x = -im; y = re;  end
            2'd2: begin x = -re; y = -im; end
            default: begin x = im; y = -re; end
        endcase
        ang = 90.0 * real'(code[1:0]);
        p = 1.0;
        for (int i = 0; i < 11; i++) begin
            f = code[2*i+2 +: 2];
            if (f == 2'b01) begin
                t = x - (y >>> i); y = y + (x >>> i); x = t;
                ang = ang + $atan(p) * 180.0 / 3.14159265358979;
            end else if (f == 2'b10) begin
                t = x + (y >>> i); y = y - (x >>> i); x = t;
                ang = ang - $atan(p) * 180.0 / 3.14159265358979;
            end
            p = p / 2.0;
        end
        ox = x;
        oy = y;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [23:0] code, input int re, input int im, input bit chk_ang);
        exp_t e;
        wait_ready();
        model(code, re, im, e.re, e.im, e.ang);
        e.chk_ang = chk_ang;
        exp_q.push_back(e);
        bus.in_code  = code;
        bus.in_re    = 16'(re);
        bus.in_im    = 16'(im);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    real  got, d;
                    e = exp_q.pop_front();
                    chk("out_re", int'(bus.out_re), e.re);
                    chk("out_im", int'(bus.out_im), e.im);
                    if (e.chk_ang) begin
                        got = $atan2(real'(bus.out_im), real'(bus.out_re)) * 180.0 / 3.14159265358979;
                        d = got - e.ang;
                        if (d > 180.0) d = d - 360.0;
                        if (d < -180.0) d = d + 360.0;
                        total++;
                        if (d > 0.1 || d < -0.1) begin
                            bad++;
                            $display("FAIL angle got=%f want=%f", got, e.ang);
                        end
                    end
                end
            end else if (!bus.out_valid) begin
                chk("idle_out_zero", {bus.out_re, bus.out_im}, 0);
            end
        end
    end

    initial begin
        logic [23:0] codes8 [8];
        logic [23:0] c;
        int n, xr, xi;
        real a;
        codes8 = '{24'h400000, 24'h020810, 24'h000004, 24'h011144,
                   24'h002154, 24'h011145, 24'h000005, 24'h020811};
        bus.in_valid = 1'b0;
        bus.in_code  = '0;
        bus.in_re    = '0;
        bus.in_im    = '0;

        #3;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_re", bus.out_re, 0);
        chk("rst_code_err", bus.code_err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_in_ready", bus.in_ready, 1);

        // Latency and basic 45 degree step.
        send(24'h000004, 1000, 0, 1'b0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.out_valid && n < 50);
        chk("latency", n, 11);
        drain();

        send(24'h000005, 1000, 0, 1'b0);
        drain();

        foreach (codes8[k]) send(codes8[k], 4096, 0, 1'b1);
        drain();

        // Consumer stall: result holds, requests ignored.
        rdy_main = 1'b0;
        send(24'h011144, -3000, 1234, 1'b0);
        model(24'h011144, -3000, 1234, xr, xi, a);
        n = 0;
        while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_code  = 24'h000004;
            bus.in_re    = 16'sd77;
            @(posedge clk); #1;
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_re", int'(bus.out_re), xr);
            chk("stall_im", int'(bus.out_im), xi);
            chk("stall_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        rdy_main = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", bus.out_valid, 0);
        chk("stall_release_ready", bus.in_ready, 1);
        n = 0;
        for (int k = 0; k < 14; k++) begin @(posedge clk); #1; if (bus.out_valid) n++; end
        chk("no_second_accept", n, 0);

        // Illegal field: skipped, sticky error.
        send(24'h00000C, 1000, 0, 1'b0);
        drain();
        chk("code_err_set", bus.code_err, 1);
        send(24'h000004, 500, -500, 1'b0);
        drain();
        chk("code_err_sticky", bus.code_err, 1);

        // Reset mid-rotation at iter 5.
        send(24'h002154, 1000, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_code_err", bus.code_err, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        void'(exp_q.pop_back());
        @(posedge clk); #1 rst = 1'b0;
        #1 chk("abort_release_ready", bus.in_ready, 1);
        send(24'h020810, -2222, 3333, 1'b0);
        drain();

        // Randomized traffic with random consumer backpressure.
        rand_rdy = 1'b1;
        for (int k = 0; k < 30; k++) begin
            c = '0;
            c[1:0] = 2'($urandom_range(0, 3));
            for (int i = 0; i < 11; i++) c[2*i+2 +: 2] = 2'($urandom_range(0, 2));
            send(c, int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 65535)) - 32768, 1'b0);
        end
        drain();
        rand_rdy = 1'b0;
        send(24'h000004, -32768, -32768, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
